// File: rtl/layer_result_pingpong_mem_pkg.sv
// Shared constants and types for the layer result ping-pong buffer.
// Default geometry, address-pair type and an index-width helper.
package layer_result_pingpong_mem_pkg;

   localparam int unsigned DEF_DATA_W = 128;
   localparam int unsigned DEF_ROWS   = 5;
   localparam int unsigned DEF_COLS   = 5;
   localparam int unsigned ADDR_W     = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
   } addr_pair_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_bank.sv
// One ROWS x COLS register array of result words.
// Synchronous write port, combinational read port; the caller guarantees in-range indices.
module result_bank
   import layer_result_pingpong_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ROWS   = DEF_ROWS,
   parameter int unsigned COLS   = DEF_COLS,
   localparam int unsigned ROW_W = idx_w(ROWS),
   localparam int unsigned COL_W = idx_w(COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [ROW_W-1:0]  i_wr_row,
   input  logic [COL_W-1:0]  i_wr_col,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ROW_W-1:0]  i_rd_row,
   input  logic [COL_W-1:0]  i_rd_col,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [ROWS][COLS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
               r_mem[r][c] <= '0;
            end
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_row][i_wr_col] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/layer_result_pingpong_mem.sv
// Two-bank ping-pong store for layer results: producer fills one bank while the
// consumer drains the other; full flags and pointers hand banks across.
module layer_result_pingpong_mem
   import layer_result_pingpong_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ROWS   = DEF_ROWS,
   parameter int unsigned COLS   = DEF_COLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [15:0]       i_wr_row,
   input  logic [15:0]       i_wr_col,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_frame_done,
   output logic              o_wr_ready,
   input  logic              i_rd_en,
   input  logic [15:0]       i_rd_row,
   input  logic [15:0]       i_rd_col,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_rd_frame_done,
   output logic              o_rd_frame_avail,
   output logic              o_addr_err,
   input  logic              i_clr_err
);

   localparam int unsigned ROW_W = idx_w(ROWS);
   localparam int unsigned COL_W = idx_w(COLS);

   logic              r_wr_ptr, r_rd_ptr;
   logic [1:0]        r_full;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_addr_err;

   addr_pair_t        w_wr_addr, w_rd_addr;
   logic              w_wr_in_range, w_rd_in_range;
   logic              w_wr_accept, w_wr_swap, w_rd_swap, w_err_set;
   logic [1:0]        w_bank_we;
   logic [ROW_W-1:0]  w_rd_row_idx;
   logic [COL_W-1:0]  w_rd_col_idx;
   logic [DATA_W-1:0] w_bank_rd_data [2];
   logic [1:0]        w_full_nxt;
   logic [DATA_W-1:0] w_rd_data_nxt;

   assign w_wr_addr = '{row: i_wr_row, col: i_wr_col};
   assign w_rd_addr = '{row: i_rd_row, col: i_rd_col};

   // Full 16-bit compares so high address bits can never alias into the array.
   assign w_wr_in_range = (w_wr_addr.row < 16'(ROWS)) && (w_wr_addr.col < 16'(COLS));
   assign w_rd_in_range = (w_rd_addr.row < 16'(ROWS)) && (w_rd_addr.col < 16'(COLS));

   assign o_wr_ready       = ~r_full[r_wr_ptr];
   assign o_rd_frame_avail = r_full[r_rd_ptr];

   assign w_wr_accept = i_wr_en & o_wr_ready & w_wr_in_range;
   assign w_wr_swap   = i_wr_frame_done & o_wr_ready;
   assign w_rd_swap   = i_rd_frame_done & o_rd_frame_avail;
   assign w_bank_we   = {w_wr_accept & r_wr_ptr, w_wr_accept & ~r_wr_ptr};
   assign w_err_set   = (i_wr_en & o_wr_ready & ~w_wr_in_range) | (i_rd_en & ~w_rd_in_range);

   // Park the read index at 0 when out of range; the data is discarded anyway.
   assign w_rd_row_idx = w_rd_in_range ? w_rd_addr.row[ROW_W-1:0] : '0;
   assign w_rd_col_idx = w_rd_in_range ? w_rd_addr.col[COL_W-1:0] : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      result_bank #(
         .DATA_W (DATA_W),
         .ROWS   (ROWS),
         .COLS   (COLS)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .i_wr_en   (w_bank_we[b]),
         .i_wr_row  (w_wr_addr.row[ROW_W-1:0]),
         .i_wr_col  (w_wr_addr.col[COL_W-1:0]),
         .i_wr_data (i_wr_data),
         .i_rd_row  (w_rd_row_idx),
         .i_rd_col  (w_rd_col_idx),
         .o_rd_data (w_bank_rd_data[b])
      );
   end

   // A wr swap needs full[wr_ptr]=0 and a rd swap needs full[rd_ptr]=1, so they never collide.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_swap) w_full_nxt[r_wr_ptr] = 1'b1;
      if (w_rd_swap) w_full_nxt[r_rd_ptr] = 1'b0;
   end

   always_comb begin
      w_rd_data_nxt = r_rd_data;
      if (i_rd_en) begin
         w_rd_data_nxt = (o_rd_frame_avail && w_rd_in_range) ? w_bank_rd_data[r_rd_ptr] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_full     <= 2'b00;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_wr_ptr   <= r_wr_ptr ^ w_wr_swap;
         r_rd_ptr   <= r_rd_ptr ^ w_rd_swap;
         r_full     <= w_full_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_rd_valid <= i_rd_en;
         r_addr_err <= w_err_set | (r_addr_err & ~i_clr_err);
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;
   assign o_addr_err = r_addr_err;

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// Directed bench for layer_result_pingpong_mem at default geometry (128-bit, 5x5).
module tb_layer_result_pingpong_mem;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en, wr_frame_done, rd_en, rd_frame_done, clr_err;
   logic [15:0]  wr_row, wr_col, rd_row, rd_col;
   logic [127:0] wr_data;
   logic         wr_ready, rd_valid, rd_frame_avail, addr_err;
   logic [127:0] rd_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   layer_result_pingpong_mem dut (
      .clk              (clk),
      .rst              (rst),
      .i_wr_en          (wr_en),
      .i_wr_row         (wr_row),
      .i_wr_col         (wr_col),
      .i_wr_data        (wr_data),
      .i_wr_frame_done  (wr_frame_done),
      .o_wr_ready       (wr_ready),
      .i_rd_en          (rd_en),
      .i_rd_row         (rd_row),
      .i_rd_col         (rd_col),
      .o_rd_data        (rd_data),
      .o_rd_valid       (rd_valid),
      .i_rd_frame_done  (rd_frame_done),
      .o_rd_frame_avail (rd_frame_avail),
      .o_addr_err       (addr_err),
      .i_clr_err        (clr_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      wr_en = 0; wr_frame_done = 0; rd_en = 0; rd_frame_done = 0; clr_err = 0;
   endtask

   task automatic write(input int r, input int c, input logic [127:0] d);
      wr_en = 1; wr_row = 16'(r); wr_col = 16'(c); wr_data = d;
      tick();
      clear_inputs();
   endtask

   task automatic wr_done();
      wr_frame_done = 1;
      tick();
      clear_inputs();
   endtask

   task automatic rd_done();
      rd_frame_done = 1;
      tick();
      clear_inputs();
   endtask

   task automatic read_chk(input string tag, input int r, input int c, input logic [127:0] exp);
      rd_en = 1; rd_row = 16'(r); rd_col = 16'(c);
      tick();
      clear_inputs();
      check({tag, "_valid"}, 128'(rd_valid), 128'(1));
      check(tag, rd_data, exp);
   endtask

   task automatic fill_bank(input int base);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            write(r, c, 128'(r * 8 + c + base));
   endtask

   initial begin
      clear_inputs();
      wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0; wr_data = 0;
      rst = 1;
      #12 rst = 0;
      check("rst_wr_ready", 128'(wr_ready), 128'(1));
      check("rst_avail", 128'(rd_frame_avail), 128'(0));
      check("rst_rd_valid", 128'(rd_valid), 128'(0));
      check("rst_rd_data", rd_data, 128'(0));
      check("rst_addr_err", 128'(addr_err), 128'(0));

      // Bank 0 gets row*8+col, then published.
      fill_bank(0);
      wr_done();
      check("f0_wr_ready", 128'(wr_ready), 128'(1));
      check("f0_avail", 128'(rd_frame_avail), 128'(1));
      read_chk("rd_2_3", 2, 3, 128'(19));
      tick();
      check("rd_valid_drop", 128'(rd_valid), 128'(0));
      check("rd_data_hold", rd_data, 128'(19));

      // Bank 1 gets row*8+col+100; both full stalls the producer.
      fill_bank(100);
      wr_done();
      check("both_full_wr_ready", 128'(wr_ready), 128'(0));
      write(0, 0, 128'hDEAD);
      check("drop_no_err", 128'(addr_err), 128'(0));
      read_chk("b0_0_0", 0, 0, 128'(0));
      read_chk("b0_4_4", 4, 4, 128'(36));
      rd_done();
      check("rel0_wr_ready", 128'(wr_ready), 128'(1));
      check("rel0_avail", 128'(rd_frame_avail), 128'(1));
      read_chk("b1_0_0", 0, 0, 128'(100));

      // Producer and consumer swap together; write lands in the closing bank,
      // read in the same cycle sees the bank being released.
      wr_en = 1; wr_row = 1; wr_col = 1; wr_data = 128'h55; wr_frame_done = 1;
      rd_en = 1; rd_row = 1; rd_col = 1; rd_frame_done = 1;
      tick();
      clear_inputs();
      check("swap_rd_released", rd_data, 128'(109));
      check("swap_wr_ready", 128'(wr_ready), 128'(1));
      check("swap_avail", 128'(rd_frame_avail), 128'(1));
      read_chk("swap_new_1_1", 1, 1, 128'h55);
      read_chk("swap_keep_2_3", 2, 3, 128'(19));

      // Out-of-range addresses, into bank 1 now being filled.
      write(5, 0, 128'hBAD);
      check("err_wr_row5", 128'(addr_err), 128'(1));
      read_chk("err_rd_0_7", 0, 7, 128'(0));
      clr_err = 1;
      tick();
      clear_inputs();
      check("err_cleared", 128'(addr_err), 128'(0));
      write(8, 0, 128'hA1);
      check("err_wr_row8", 128'(addr_err), 128'(1));
      clr_err = 1; rd_en = 1; rd_row = 0; rd_col = 7;
      tick();
      clear_inputs();
      check("err_set_wins", 128'(addr_err), 128'(1));
      clr_err = 1;
      tick();
      clear_inputs();
      check("err_cleared2", 128'(addr_err), 128'(0));

      // Publish bank 1 and confirm neither bad write aliased into it.
      rd_done();
      check("empty_avail", 128'(rd_frame_avail), 128'(0));
      read_chk("rd_no_frame", 2, 3, 128'(0));
      wr_done();
      read_chk("noalias_0_0", 0, 0, 128'(100));
      read_chk("b1_4_4", 4, 4, 128'(136));

      // Reset mid-frame with a pending error and a read in flight.
      read_chk("pre_rst_err_rd", 0, 9, 128'(0));
      check("pre_rst_err", 128'(addr_err), 128'(1));
      rd_en = 1; rd_row = 4; rd_col = 4;
      @(posedge clk);
      #2 rst = 1;
      #1;
      check("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
      check("mid_rst_rd_data", rd_data, 128'(0));
      check("mid_rst_wr_ready", 128'(wr_ready), 128'(1));
      check("mid_rst_avail", 128'(rd_frame_avail), 128'(0));
      check("mid_rst_addr_err", 128'(addr_err), 128'(0));
      clear_inputs();
      #1 rst = 0;
      write(0, 0, 128'h1234);
      wr_done();
      read_chk("post_rst_0_0", 0, 0, 128'h1234);
      read_chk("post_rst_4_4", 4, 4, 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
